mem_arbiter: RTL and testbench

Two-port arbiter and transaction sequencer in front of the `memory` block. It shares the single memory port between the core's instruction-fetch port and data port, drives the memory's active-low chip enable, detects completion from `busy`/`valid`/`load_access_fault`, and returns data or a fault to the winning requester. A watchdog aborts transactions that never complete.

---
 rtl/mem_arb_pkg.sv | 37 +++
 rtl/bus_watchdog.sv | 33 +++
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Imported by the arbiter top and its watchdog.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } arb_state_t;

   localparam logic PORT_DATA   = 1'b0;
   localparam logic PORT_IFETCH = 1'b1;

   localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  funct3;
      logic        we;
   } mem_req_t;

   // Lone requester wins; on a tie the port that did not win last time wins.
   function automatic logic pick_port(input logic [1:0] req,
                                      input logic       last);
      logic p;
      unique case (req)
         2'b01:   p = PORT_DATA;
         2'b10:   p = PORT_IFETCH;
         2'b11:   p = ~last;
         default: p = last;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Up-counter that flags a transaction running past LIMIT cycles.
// Cleared while idle, counts while enabled, saturates at the limit.
module bus_watchdog
   import mem_arb_pkg::*;
#(
   parameter int LIMIT = TIMEOUT_CYCLES_DEFAULT,
   localparam int W    = $clog2(LIMIT + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic expired
);

   localparam logic [W-1:0] LAST = W'(LIMIT - 1);

   logic [W-1:0] cnt;

   // Expiry is raised in the LIMIT-th enabled cycle after a clear.
   assign expired = en && (cnt == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (en && !expired) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between data and ifetch.
// Sequences IDLE/ISSUE/WAIT/DONE with a watchdog on the WAIT phase.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   input  logic [2:0]  funct3_0,
   input  logic [2:0]  funct3_1,
   input  logic        we0,
   input  logic        we1,
   output logic [1:0]  ack,
   output logic [31:0] rdata,
   output logic        fault,
   output logic        timeout,
   output logic        mem_ce,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_datain,
   output logic [2:0]  mem_funct3,
   output logic        mem_memwrite,
   input  logic [31:0] mem_dataout,
   input  logic        mem_busy,
   input  logic        mem_valid,
   input  logic        mem_fault
);

   arb_state_t state;
   logic       grant_idx;
   logic       last_grant;
   logic       win;
   logic       wd_expired;
   logic       wait_exit;
   mem_req_t   p0;
   mem_req_t   p1;
   mem_req_t   pick;
   mem_req_t   pay;

   assign p0   = {addr0, wdata0, funct3_0, we0};
   assign p1   = {addr1, wdata1, funct3_1, we1};
   assign win  = pick_port(req, last_grant);
   assign pick = win ? p1 : p0;

   // Payload register stays frozen from ISSUE through DONE.
   assign mem_addr     = pay.addr;
   assign mem_datain   = pay.wdata;
   assign mem_funct3   = pay.funct3;
   assign mem_memwrite = pay.we;

   assign wait_exit = mem_fault || !mem_busy || wd_expired;

   bus_watchdog #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_wd (
      .clk    (clk),
      .reset  (reset),
      .clear  (state != WAIT),
      .en     (state == WAIT),
      .expired(wd_expired)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         grant_idx  <= PORT_DATA;
         last_grant <= PORT_IFETCH;
         pay        <= '0;
         mem_ce     <= 1'b1;
         ack        <= 2'b00;
         fault      <= 1'b0;
         timeout    <= 1'b0;
         rdata      <= '0;
      end else begin
         ack <= 2'b00;
         unique case (state)
            IDLE: begin
               if (|req) begin
                  grant_idx <= win;
                  pay       <= pick;
                  mem_ce    <= 1'b0;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               state <= WAIT;
            end
            WAIT: begin
               if (mem_fault) begin
                  fault <= 1'b1;
               end else if (!mem_busy) begin
                  if (mem_valid) rdata <= mem_dataout;
                  fault <= 1'b0;
               end else if (wd_expired) begin
                  fault   <= 1'b1;
                  timeout <= 1'b1;
               end
               if (wait_exit) begin
                  mem_ce <= 1'b1;
                  ack    <= grant_idx ? 2'b10 : 2'b01;
                  state  <= DONE;
               end
            end
            DONE: begin
               last_grant <= grant_idx;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic
// against a cycle-count reference model and a reactive memory model.
module tb_mem_arbiter;

   localparam int T = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic [2:0]  funct3_0, funct3_1;
   logic        we0, we1;
   logic [1:0]  ack;
   logic [31:0] rdata;
   logic        fault, timeout, mem_ce;
   logic [31:0] mem_addr, mem_datain;
   logic [2:0]  mem_funct3;
   logic        mem_memwrite;
   logic [31:0] mem_dataout;
   logic        mem_busy, mem_valid, mem_fault;

   int          checks = 0;
   int          errors = 0;

   bit          m_last;
   logic [31:0] m_rdata;
   bit          m_timeout;

   int          mcnt;
   int          cfg_b;
   bit          cfg_flt;
   bit          cfg_hang;
   logic [31:0] cfg_data;

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .addr0       (addr0),
      .addr1       (addr1),
      .wdata0      (wdata0),
      .wdata1      (wdata1),
      .funct3_0    (funct3_0),
      .funct3_1    (funct3_1),
      .we0         (we0),
      .we1         (we1),
      .ack         (ack),
      .rdata       (rdata),
      .fault       (fault),
      .timeout     (timeout),
      .mem_ce      (mem_ce),
      .mem_addr    (mem_addr),
      .mem_datain  (mem_datain),
      .mem_funct3  (mem_funct3),
      .mem_memwrite(mem_memwrite),
      .mem_dataout (mem_dataout),
      .mem_busy    (mem_busy),
      .mem_valid   (mem_valid),
      .mem_fault   (mem_fault)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Memory: mcnt counts cycles with ce low (ISSUE is 1).
   task automatic mem_drive();
      mem_busy    = cfg_hang ? (mcnt >= 2)
                             : (mcnt >= 2 && mcnt <= cfg_b + 1);
      mem_fault   = cfg_flt && mcnt >= 2;
      mem_valid   = !cfg_hang && !cfg_flt && !mem_memwrite
                    && mcnt == cfg_b + 2;
      mem_dataout = cfg_data;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (!mem_ce) mcnt++;
      else mcnt = 0;
      mem_drive();
   endtask

   task automatic rand_payload();
      addr0    = $urandom;
      addr1    = $urandom;
      wdata0   = $urandom;
      wdata1   = $urandom;
      funct3_0 = 3'($urandom_range(0, 7));
      funct3_1 = 3'($urandom_range(0, 7));
      we0      = 1'($urandom_range(0, 1));
      we1      = 1'($urandom_range(0, 1));
   endtask

   // Called in an IDLE cycle; ends in the IDLE cycle after DONE.
   task automatic do_txn(input logic [1:0] r, input int b, input bit flt,
                         input bit hang, input logic [31:0] data,
                         input bit keep);
      bit          w;
      int          exp_t, t, lowcnt;
      logic [31:0] e_addr, e_wd;
      logic [3:0]  e_fw;
      bit          e_we;
      cfg_b    = b;
      cfg_flt  = flt;
      cfg_hang = hang;
      cfg_data = data;
      if (r == 2'b01) w = 1'b0;
      else if (r == 2'b10) w = 1'b1;
      else w = !m_last;
      e_addr = w ? addr1 : addr0;
      e_wd   = w ? wdata1 : wdata0;
      e_we   = w ? we1 : we0;
      e_fw   = {w ? funct3_1 : funct3_0, e_we};
      exp_t  = hang ? T + 2 : (flt ? 3 : b + 3);
      req    = r;
      t      = 0;
      lowcnt = 0;
      do begin
         tick();
         t++;
         if (!mem_ce) lowcnt++;
         if (!mem_ce || ack != 2'b00) begin
            check("pay_addr", mem_addr, e_addr);
            check("pay_wdata", mem_datain, e_wd);
            check("pay_f3_we", {28'd0, mem_funct3, mem_memwrite},
                  {28'd0, e_fw});
         end
      end while (ack == 2'b00 && t < 40);
      check("ack_cycle", t, exp_t);
      check("ack_port", {30'd0, ack}, w ? 32'd2 : 32'd1);
      check("ce_low_cycles", lowcnt, exp_t - 1);
      check("ce_done", {31'd0, mem_ce}, 32'd1);
      if (hang) m_timeout = 1'b1;
      if (!hang && !flt && !e_we) m_rdata = data;
      check("fault", {31'd0, fault}, {31'd0, (hang || flt)});
      check("timeout", {31'd0, timeout}, {31'd0, m_timeout});
      check("rdata", rdata, m_rdata);
      m_last = w;
      tick();
      check("ack_once", {30'd0, ack}, 32'd0);
      check("ce_idle", {31'd0, mem_ce}, 32'd1);
      if (!keep) req = 2'b00;
   endtask

   initial begin
      reset = 1'b0;
      req   = 2'b00;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      funct3_0 = '0; funct3_1 = '0; we0 = 1'b0; we1 = 1'b0;
      mcnt = 0; cfg_b = 0; cfg_flt = 0; cfg_hang = 0; cfg_data = '0;
      m_last = 1'b1; m_rdata = '0; m_timeout = 1'b0;
      mem_drive();
      repeat (3) @(posedge clk);
      #1;
      check("rst_ce", {31'd0, mem_ce}, 32'd1);
      check("rst_ack", {30'd0, ack}, 32'd0);
      check("rst_fault", {31'd0, fault}, 32'd0);
      check("rst_timeout", {31'd0, timeout}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_datain", mem_datain, 32'd0);
      check("rst_f3_we", {28'd0, mem_funct3, mem_memwrite}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      tick();

      // Continuous tie: expect ports 0,1,0,1.
      rand_payload();
      we0 = 1'b0; we1 = 1'b0;
      for (int i = 0; i < 4; i++)
         do_txn(2'b11, 1, 1'b0, 1'b0, $urandom, i < 3);

      // Single read.
      addr0 = 32'h0000_0010; we0 = 1'b0;
      do_txn(2'b01, 5, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0);

      // Fault on ifetch port.
      addr1 = 32'h0090_0000; we1 = 1'b0;
      do_txn(2'b10, 0, 1'b1, 1'b0, $urandom, 1'b0);

      // GPIO write.
      addr0 = 32'h0080_0000; we0 = 1'b1; wdata0 = 32'h0000_00A5;
      do_txn(2'b01, 1, 1'b0, 1'b0, $urandom, 1'b0);

      // Watchdog timeout, then a normal read.
      we0 = 1'b0;
      do_txn(2'b01, 0, 1'b0, 1'b1, $urandom, 1'b0);
      do_txn(2'b01, 2, 1'b0, 1'b0, $urandom, 1'b0);

      for (int i = 0; i < 24; i++) begin
         rand_payload();
         do_txn(2'($urandom_range(1, 3)), $urandom_range(0, 5),
                $urandom_range(0, 7) == 0, 1'b0, $urandom, 1'b0);
      end

      // Asynchronous reset in WAIT.
      cfg_hang = 1'b1;
      req = 2'b11;
      repeat (3) tick();
      #2;
      reset = 1'b0;
      #1;
      check("arst_ce", {31'd0, mem_ce}, 32'd1);
      check("arst_ack", {30'd0, ack}, 32'd0);
      check("arst_timeout", {31'd0, timeout}, 32'd0);
      check("arst_rdata", rdata, 32'd0);
      req = 2'b00;
      repeat (2) begin
         tick();
         check("arst_hold_ack", {30'd0, ack}, 32'd0);
      end
      @(negedge clk);
      reset = 1'b1;
      m_last = 1'b1; m_rdata = '0; m_timeout = 1'b0;
      tick();
      rand_payload();
      do_txn(2'b11, 1, 1'b0, 1'b0, $urandom, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
